aes_key_expander: RTL and testbench

Sequential AES-128 key expansion stage, directly upstream of the encryption and decryption cores. Accepts a 128-bit cipher key on a start handshake and generates one round key per clock into an internal 11-entry buffer. Once the full schedule is ready, it exposes the round keys through an indexed read port for the round engines.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_key_expander_if.sv | 18 +
 rtl/aes_sbox.sv | 36 +++
 rtl/aes_key_expander.sv | 135 +++++++++++++
 tb/tb_aes_key_expander.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key schedule and round engines.
// No latency of its own; pure declarations and one combinational helper.
// No flow control; consumers decide how these items are used.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] aes_key_t;
    typedef logic [31:0]  aes_word_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_FINISH = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Request/read bundle between the key expander and its round-engine consumers.
// No latency; wires only.
// No backpressure: start is accepted only when the expander is idle, otherwise dropped.
interface aes_key_expander_if;
    import aes_pkg::*;

    logic       start;
    aes_key_t   key;
    logic       busy;
    logic       done;
    logic       keys_valid;
    logic [3:0] rd_idx;
    aes_key_t   rd_key;

    modport master (output start, key, rd_idx, input busy, done, keys_valid, rd_key);
    modport slave  (input start, key, rd_idx, output busy, done, keys_valid, rd_key);

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in, one byte out.
// Zero cycles: purely combinational table lookup.
// No flow control.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sub_in,
    output logic [7:0] sub_out
);

    // Row 0 of the FIPS-197 table sits in the top bits, so byte v lives at [2047-8v -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_base;

    assign bit_base = {sub_in, 3'b000};
    assign sub_out  = SBOX_TABLE[11'd2047 - bit_base -: 8];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: one round key per clock into an 11-slot buffer, indexed read port; AES_KEYEXP_FLAT_EN adds a flat 1408-bit schedule output.
// Latency: slot 0 one edge after start, slot 10 and done eleven cycles after acceptance; rd_key is combinational.
// No backpressure: start is taken only in IDLE and dropped otherwise; consumers gate reads on keys_valid.
module aes_key_expander #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    aes_key_expander_if.slave       bus
`ifdef AES_KEYEXP_FLAT_EN
    ,
    output logic [128*(NUM_ROUNDS+1)-1:0] keys_flat
`endif
);
    import aes_pkg::aes_key_t;
    import aes_pkg::aes_word_t;
    import aes_pkg::RCON_INIT;
    import aes_pkg::xtime;
    import aes_pkg::ST_IDLE;
    import aes_pkg::ST_EXPAND;
    import aes_pkg::ST_FINISH;

    localparam int         NUM_SLOTS  = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] EXPAND = ST_EXPAND;
    localparam logic [1:0] FINISH = ST_FINISH;

    // The datapath and rcon sequence are fixed to AES-128.
    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_key_expander supports NUM_ROUNDS = 10 only");
    end

    logic [1:0] state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       keys_valid_q, keys_valid_d;
    aes_key_t   slot_q [NUM_SLOTS];
    aes_key_t   slot_d [NUM_SLOTS];

    logic [3:0] prev_idx;
    aes_key_t   prev_key;
    aes_word_t  w0, w1, w2, w3;
    aes_word_t  rot_w, sub_w, temp_w;
    aes_word_t  n0, n1, n2, n3;

    // Round r is derived from slot r-1; the guard keeps the index legal outside EXPAND.
    assign prev_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
    assign prev_key = slot_q[prev_idx];
    assign {w0, w1, w2, w3} = prev_key;
    assign rot_w  = {w3[23:0], w3[31:24]};
    assign temp_w = sub_w ^ {rcon_q, 24'h0};
    assign n0 = w0 ^ temp_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .sub_in  (rot_w[8*g +: 8]),
            .sub_out (sub_w[8*g +: 8])
        );
    end

    // Next-state: load the cipher key, then one schedule word group per EXPAND cycle.
    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        rcon_d       = rcon_q;
        keys_valid_d = keys_valid_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    slot_d[0]    = bus.key;
                    keys_valid_d = 1'b0;
                    rcon_d       = RCON_INIT;
                    round_d      = 4'd1;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                slot_d[round_q] = {n0, n1, n2, n3};
                rcon_d          = xtime(rcon_q);
                round_d         = round_q + 4'd1;
                if (round_q == LAST_ROUND) begin
                    state_d      = FINISH;
                    keys_valid_d = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            round_q      <= 4'd0;
            rcon_q       <= 8'h00;
            keys_valid_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            rcon_q       <= rcon_d;
            keys_valid_q <= keys_valid_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign bus.busy       = (state_q == EXPAND);
    assign bus.done       = (state_q == FINISH);
    assign bus.keys_valid = keys_valid_q;
    assign bus.rd_key     = (bus.rd_idx <= LAST_ROUND) ? slot_q[bus.rd_idx] : '0;

`ifdef AES_KEYEXP_FLAT_EN
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_flat
        assign keys_flat[128*s +: 128] = slot_q[s];
    end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-schedule vectors.
// Checks reset state, schedule contents, handshake timing, ignored starts and mid-run reset.
// Summary line reports vectors applied and miscompares.
module tb_aes_key_expander;
    import aes_pkg::*;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_SLOT1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_SLOT2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A_SLOT10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z    = 128'h0;
    localparam logic [127:0] Z_SLOT1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_SLOT2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] Z_SLOT10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    aes_key_expander_if bus ();

`ifdef AES_KEYEXP_FLAT_EN
    logic [1407:0] keys_flat;
`endif

    aes_key_expander #(.NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef AES_KEYEXP_FLAT_EN
        ,
        .keys_flat (keys_flat)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        bus.rd_idx = idx;
        #1;
        check_vec(tag, bus.rd_key, exp);
    endtask

    // Drive start for one edge; optionally keep it high with another key afterwards.
    task automatic apply_start(input logic [127:0] k, input bit hold, input logic [127:0] hold_key);
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        @(posedge clk);
        #1;
        if (hold) bus.key = hold_key;
        else      bus.start = 1'b0;
    endtask

    // Called in the first cycle after acceptance; returns at the cycle done is seen.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 1;
        busy_cnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bcnt;

        bus.start  = 1'b0;
        bus.key    = '0;
        bus.rd_idx = '0;

        // Reset state
        #12;
        check_vec("rst_busy", 128'(bus.busy), 128'd0);
        check_vec("rst_done", 128'(bus.done), 128'd0);
        check_vec("rst_kv",   128'(bus.keys_valid), 128'd0);
        for (int i = 0; i < 16; i++) check_slot($sformatf("rst_slot%0d", i), 4'(i), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference key A
        apply_start(KEY_A, 1'b0, '0);
        check_vec("a_busy_e0", 128'(bus.busy), 128'd1);
        check_vec("a_kv_e0",   128'(bus.keys_valid), 128'd0);
        check_slot("a_slot0_early", 4'd0, KEY_A);
        check_slot("a_idx12_expand", 4'd12, 128'd0);
        wait_done(cyc, bcnt);
        check_vec("a_latency", 128'(cyc), 128'd11);
        check_vec("a_busy_cycles", 128'(bcnt), 128'd10);
        check_vec("a_busy_fin", 128'(bus.busy), 128'd0);
        check_vec("a_kv_fin", 128'(bus.keys_valid), 128'd1);
        @(posedge clk);
        #1;
        check_vec("a_done_drop", 128'(bus.done), 128'd0);
        check_vec("a_kv_hold", 128'(bus.keys_valid), 128'd1);
        check_slot("a_slot0", 4'd0, KEY_A);
        check_slot("a_slot1", 4'd1, A_SLOT1);
        check_slot("a_slot2", 4'd2, A_SLOT2);
        check_slot("a_slot10", 4'd10, A_SLOT10);
        check_slot("a_idx11", 4'd11, 128'd0);
        check_slot("a_idx15", 4'd15, 128'd0);
`ifdef AES_KEYEXP_FLAT_EN
        check_vec("a_flat10", keys_flat[1280 +: 128], A_SLOT10);
        check_vec("a_flat1",  keys_flat[128 +: 128], A_SLOT1);
`endif

        // All-zero key with start held high carrying key A during expansion
        apply_start(KEY_Z, 1'b1, KEY_A);
        check_vec("z_kv_e0", 128'(bus.keys_valid), 128'd0);
        wait_done(cyc, bcnt);
        bus.start = 1'b0;
        check_vec("z_latency", 128'(cyc), 128'd11);
        check_vec("z_busy_cycles", 128'(bcnt), 128'd10);
        check_vec("z_kv_fin", 128'(bus.keys_valid), 128'd1);
        @(posedge clk);
        #1;
        check_vec("z_busy_idle", 128'(bus.busy), 128'd0);
        check_slot("z_slot0", 4'd0, KEY_Z);
        check_slot("z_slot1", 4'd1, Z_SLOT1);
        check_slot("z_slot2", 4'd2, Z_SLOT2);
        check_slot("z_slot10", 4'd10, Z_SLOT10);
        check_slot("z_idx13", 4'd13, 128'd0);

        // Reset in the 5th EXPAND cycle
        apply_start(KEY_A, 1'b0, '0);
        repeat (4) @(posedge clk);
        #1;
        check_vec("r_busy_pre", 128'(bus.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check_vec("r_busy", 128'(bus.busy), 128'd0);
        check_vec("r_done", 128'(bus.done), 128'd0);
        check_vec("r_kv",   128'(bus.keys_valid), 128'd0);
        for (int i = 0; i < 11; i++) check_slot($sformatf("r_slot%0d", i), 4'(i), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh run after reset release
        apply_start(KEY_A, 1'b0, '0);
        wait_done(cyc, bcnt);
        check_vec("f_latency", 128'(cyc), 128'd11);
        check_vec("f_busy_cycles", 128'(bcnt), 128'd10);
        check_slot("f_slot1", 4'd1, A_SLOT1);
        check_slot("f_slot10", 4'd10, A_SLOT10);

        // start during the done cycle is dropped; one cycle later it is taken
        bus.start = 1'b1;
        bus.key   = KEY_Z;
        @(posedge clk);
        #1;
        check_vec("d_busy_ignored", 128'(bus.busy), 128'd0);
        check_vec("d_kv_kept", 128'(bus.keys_valid), 128'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_vec("d_busy_taken", 128'(bus.busy), 128'd1);
        check_vec("d_kv_cleared", 128'(bus.keys_valid), 128'd0);
        wait_done(cyc, bcnt);
        check_vec("d_latency", 128'(cyc), 128'd11);
        check_slot("d_slot1", 4'd1, Z_SLOT1);
        check_slot("d_slot10", 4'd10, Z_SLOT10);
        check_vec("d_kv_fin", 128'(bus.keys_valid), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
